// File: rtl/al_accel_ibuf_ctrl.sv
// Input-buffer sequencer: fetches 3-row bands of the feature map into the
// ibuf banks and shifts out one 3x3 window per PE handshake, serpentine order.
module al_accel_ibuf_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_w_words,
  input  logic [DIM_W-1:0]  cfg_h,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ibuf_di,
  output logic              ibuf_ld_wrn,
  output logic [1:0]        ibuf_bank_sel,
  output logic              ibuf_di_revert,
  output logic [2:0]        ibuf_conv_wstrb,
  output logic              ibuf_conv_fi_load,
  output logic              ibuf_conv_se_load,
  output logic              ibuf_enb,
  input  logic              pe_ready,
  output logic              win_valid,
  output logic [DIM_W-1:0]  win_row,
  output logic [DIM_W+1:0]  win_col
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_DOWN, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] b_q, b_d;
  logic [DIM_W-1:0] g_q, g_d;
  logic [1:0]       l_q, l_d;
  logic [1:0]       s_q, s_d;
  logic [DIM_W+1:0] k_q, k_d;
  logic             rev_q, rev_d;
  logic             err_q, err_d;

  logic [DIM_W-1:0]  wg;
  logic [ADDR_W-1:0] row_a;
  logic [DIM_W+1:0]  wlen;
  logic [DIM_W:0]    g_nx;
  logic [DIM_W:0]    b_nx3;
  logic              fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      g_q     <= '0;
      l_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      rev_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      g_q     <= g_d;
      l_q     <= l_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rev_q   <= rev_d;
      err_q   <= err_d;
    end
  end

  assign ibuf_di         = mem_rdata;
  assign ibuf_conv_wstrb = 3'd0;
  assign ibuf_di_revert  = rev_q;
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    g_d     = g_q;
    l_d     = l_q;
    s_d     = s_q;
    k_d     = k_q;
    rev_d   = rev_q;
    err_d   = err_q;

    done              = 1'b0;
    cfg_err           = 1'b0;
    mem_req           = 1'b0;
    mem_addr          = '0;
    ibuf_ld_wrn       = 1'b0;
    ibuf_bank_sel     = 2'd0;
    ibuf_conv_fi_load = 1'b0;
    ibuf_conv_se_load = 1'b0;
    ibuf_enb          = 1'b0;
    win_valid         = 1'b0;
    win_row           = '0;
    win_col           = '0;

    // R2L bands fetch word groups from the right edge inward
    wg    = rev_q ? (cfg_w_words - DIM_W'(1) - g_q) : g_q;
    row_a = ADDR_W'(b_q) + ADDR_W'(l_q);
    wlen  = {cfg_w_words, 2'b00};
    g_nx  = {1'b0, g_q} + (DIM_W+1)'(1);
    b_nx3 = {1'b0, b_q} + (DIM_W+1)'(3);
    fire  = (k_q < (DIM_W+2)'(2)) || pe_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_h < DIM_W'(3) || cfg_w_words == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            b_d     = '0;
            g_d     = '0;
            l_d     = '0;
            s_d     = '0;
            k_d     = '0;
            rev_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        mem_req  = 1'b1;
        mem_addr = cfg_base + row_a * ADDR_W'(cfg_w_words)
                 + ADDR_W'(wg);
        if (mem_gnt) begin
          ibuf_ld_wrn   = 1'b1;
          ibuf_bank_sel = l_q + 2'd1;
          ibuf_enb      = 1'b1;
          if (l_q == 2'd2) begin
            l_d     = '0;
            s_d     = '0;
            state_d = S_SHIFT;
          end else begin
            l_d = l_q + 2'd1;
          end
        end
      end
      S_SHIFT: begin
        win_row   = b_q;
        win_col   = rev_q ? (wlen - (DIM_W+2)'(1) - k_q)
                          : (k_q - (DIM_W+2)'(2));
        win_valid = (k_q >= (DIM_W+2)'(2)) && pe_ready;
        if (fire) begin
          ibuf_enb = 1'b1;
          s_d      = s_q + 2'd1;
          k_d      = k_q + (DIM_W+2)'(1);
          if (s_q == 2'd3) begin
            if (g_nx < {1'b0, cfg_w_words}) begin
              g_d     = g_q + DIM_W'(1);
              l_d     = '0;
              state_d = S_LOAD;
            end else if (b_nx3 < {1'b0, cfg_h}) begin
              state_d = S_DOWN;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DOWN: begin
        ibuf_conv_fi_load = 1'b1;
        ibuf_conv_se_load = 1'b1;
        ibuf_enb          = 1'b1;
        b_d     = b_q + DIM_W'(1);
        g_d     = '0;
        k_d     = '0;
        l_d     = '0;
        rev_d   = ~rev_q;
        state_d = S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        cfg_err = err_q;
        err_d   = 1'b0;
        rev_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/al_accel_ibuf_ctrl.md
# al_accel_ibuf_ctrl

Sequencer for the convolution input buffer (`al_accel_ibuf`). It fetches feature-map words from memory and writes them into the three ibuf banks, then issues shift cycles to the ibuf. It walks the map in serpentine 3-row bands: even bands left-to-right, odd bands right-to-left. It presents one 3×3 window per accepted shift to the PE array and pulses `done` when the whole map has been covered.

## Interface
Parameters:
- `ADDR_W`, 16, memory word-address width
- `DIM_W`, 8, width of the dimension config fields

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high; one clock; reset polarity and synchronicity are fixed
- `start`  input  1  begin a pass; sampled only in IDLE
- `cfg_base`  input  ADDR_W  word address of pixel (0,0); row-major, 4 pixels per 32-bit word
- `cfg_w_words`  input  DIM_W  map width in words (W = 4·cfg_w_words pixels)
- `cfg_h`  input  DIM_W  map height in rows (H)
- `busy`  output  1  high from the cycle after start is accepted through the DONE cycle
- `done`  output  1  one-cycle pulse at end of pass
- `cfg_err`  output  1  one-cycle pulse with `done` when config is illegal
- `mem_req`  output  1  read request
- `mem_addr`  output  ADDR_W  read address; held stable while `mem_req`=1 and `mem_gnt`=0
- `mem_gnt`  input  1  grant; `mem_rdata` is valid in the same cycle
- `mem_rdata`  input  32  read data
- `ibuf_di`  output  32  equals `mem_rdata` (combinational)
- `ibuf_ld_wrn`  output  1  1 = write bank, 0 = shift
- `ibuf_bank_sel`  output  2  bank to write, 1..3
- `ibuf_di_revert`  output  1  0 for L2R bands, 1 for R2L bands
- `ibuf_conv_wstrb`  output  3  always 3'd0
- `ibuf_conv_fi_load`  output  1  window flush pulse at band change
- `ibuf_conv_se_load`  output  1  same as `ibuf_conv_fi_load`
- `ibuf_enb`  output  1  ibuf clock-enable; high only on write, shift, or flush cycles
- `pe_ready`  input  1  PE accepts a window this cycle
- `win_valid`  output  1  ibuf window outputs valid this cycle
- `win_row`  output  DIM_W  top row of the current window
- `win_col`  output  DIM_W+2  leftmost pixel column of the current window

## Operation
States:
- **IDLE**
  - On `start`: if `cfg_h`<3 or `cfg_w_words`=0, go to DONE with `cfg_err`.
  - Otherwise clear the counters: band b=0, word index g, load count l=0, shift count k=0. Go to LOAD.
- **LOAD**
  - `mem_req`=1.
  - `mem_addr` = `cfg_base` + (b+l)·`cfg_w_words` + wg.
  - wg = g for an L2R band; wg = `cfg_w_words`−1−g for an R2L band.
  - On `mem_gnt`: `ibuf_ld_wrn`=1, `ibuf_bank_sel`=l+1, `ibuf_enb`=1, l++.
  - After the third grant, go to SHIFT with s=0.
- **SHIFT** (4 shift slots per word, s=0..3)
  - A slot fires when priming (k<2) or when `pe_ready`=1.
  - On fire: `ibuf_ld_wrn`=0, `ibuf_enb`=1, s++, k++.
  - `win_valid`=1 when k≥2 and `pe_ready`=1 (i.e. the slot fires).
  - `win_row`=b. `win_col`=k−2 for L2R, W−1−k for R2L.
  - When s=3 fires:
    - if g<`cfg_w_words`−1: g++, l=0, go to LOAD;
    - else if b+3<`cfg_h`: go to DOWN;
    - else go to DONE.
- **DOWN** (1 cycle)
  - `ibuf_conv_fi_load`=`ibuf_conv_se_load`=1, `ibuf_enb`=1.
  - b++, g=0, k=0, l=0; toggle direction. Go to LOAD.
- **DONE** (1 cycle)
  - `done`=1. Go to IDLE.

Rules:
- Windows per band: W−2. Total windows: (W−2)·(H−2). Memory grants: 3·`cfg_w_words`·(H−2).
- `ibuf_enb`=0 in every other cycle: LOAD without grant, stalled SHIFT, IDLE, DONE.
- `start` while busy is ignored.

## Timing
- Reset: state IDLE; counters 0; direction L2R. All outputs 0, except `ibuf_di`, which follows `mem_rdata`.
- Reset mid-pass: IDLE on the next edge with no further `mem_req`. A grant arriving in the reset cycle is dropped.
- `ibuf_di`, `ibuf_ld_wrn`, `ibuf_enb` and `ibuf_bank_sel` in LOAD are combinational from `mem_gnt`. All other outputs are decoded from registered state.
- Zero-stall cost: 7 cycles per word group and 1 cycle per DOWN.
- `start` sampled at cycle 0 → first LOAD at cycle 1 → `done` at cycle 1 + (H−2)·(7·`cfg_w_words`) + (H−3).
- `mem_gnt` low: LOAD holds `mem_addr`; no ibuf activity.
- `pe_ready` low: non-priming slots stall with `win_valid`=0 and `ibuf_enb`=0.

## Test plan
- **Basic pass.** `cfg_w_words`=2, H=4, base=0x100, grant and ready tied high.
  - `mem_addr` sequence: 0x100,102,104, 101,103,105, 0x103,105,107, 102,104,106.
  - 12 `win_valid` with band-0 `win_col` 0..5 and band-1 `win_col` 5..0.
  - `ibuf_di_revert`=1 in band 1.
  - Flush pulse at cycle 15; `done` at cycle 30.
- **Memory stall.** Same config, `mem_gnt` low for 5 cycles on the second request.
  - `mem_addr` holds 0x102, no `ibuf_enb`; `done` at cycle 35.
- **PE backpressure.** `pe_ready` low for 3 cycles during band-0 slot k=4.
  - No `win_valid` and `ibuf_enb`=0 for those cycles; window count still 12; `done` at 33.
- **Illegal config.** `cfg_h`=2.
  - `done` and `cfg_err` at cycle 1; no `mem_req`.
- **Reset mid-pass.** Assert `reset` at cycle 10 for 1 cycle.
  - All outputs 0 at cycle 11; a new `start` reproduces the basic-pass address sequence exactly.
- **Start while busy.** Pulse `start` at cycle 8.
  - Ignored; exactly one `done`.
